// File: rtl/mod_147_rx_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_147_rx_decode_if
//  Description : Symbol-in / MII-out bundle for the 10BASE-T1S PCS receive
//                symbol decoder. master = symbol source and MII consumer,
//                slave = decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface mod_147_rx_decode_if;
  logic [4:0] rx_sym;
  logic       rx_sym_valid;
  logic [1:0] rx_cmd;
  logic       RX_DV;
  logic [3:0] RXD;
  logic       RX_ER;
  logic       CRS;
  logic [7:0] sym_err_cnt;

  modport master (
    output rx_sym, rx_sym_valid,
    input  rx_cmd, RX_DV, RXD, RX_ER, CRS, sym_err_cnt
  );

  modport slave (
    input  rx_sym, rx_sym_valid,
    output rx_cmd, RX_DV, RXD, RX_ER, CRS, sym_err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mod_147_rx_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mod_147_rx_decode
//  Description : 10BASE-T1S PCS receive symbol decoder. Recovers frames
//                (SYNC,SYNC,SSD,data,ESD,ESDOK), decodes idle command symbols
//                and drives the registered MII receive outputs.
//                Optional macro RX_SYM_ERR_CNT_EN enables the saturating
//                invalid-symbol counter on sym_err_cnt (otherwise tied to 0).
//  Revision    : 1.0  initial release
// ============================================================================
module mod_147_rx_decode #(
  parameter int CMD_REPEAT    = 2,
  parameter int SILENCE_ABORT = 2
) (
  input  wire logic          clk,
  input  wire logic          pcs_reset,
  mod_147_rx_decode_if.slave rx_if
);

  localparam logic [4:0] c_sym_silence = 5'b11111;
  localparam logic [4:0] c_sym_sync    = 5'b11000;
  localparam logic [4:0] c_sym_ssd     = 5'b10001;
  localparam logic [4:0] c_sym_esd     = 5'b01101;
  localparam logic [4:0] c_sym_esdok   = 5'b00111;
  localparam logic [4:0] c_sym_beacon  = 5'b11001;
  localparam logic [4:0] c_sym_commit  = 5'b00100;
  localparam logic [4:0] c_sym_hbeat   = 5'b01000;

  localparam logic [1:0] c_cmd_beacon  = 2'b00;
  localparam logic [1:0] c_cmd_commit  = 2'b01;
  localparam logic [1:0] c_cmd_hbeat   = 2'b10;
  localparam logic [1:0] c_cmd_none    = 2'b11;

  localparam logic [2:0] c_cmd_repeat  = 3'(CMD_REPEAT);
  localparam logic [2:0] c_sil_abort   = 3'(SILENCE_ABORT);

  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_sync1    = 3'd1;
  localparam logic [2:0] c_st_sync2    = 3'd2;
  localparam logic [2:0] c_st_data     = 3'd3;
  localparam logic [2:0] c_st_esd_seen = 3'd4;

  logic [2:0] r_state,    w_state_nxt;
  logic [2:0] r_cmd_cnt,  w_cmd_cnt_nxt;
  logic [1:0] r_last_cmd, w_last_cmd_nxt;
  logic [2:0] r_sil_cnt,  w_sil_cnt_nxt;
  logic [1:0] r_rx_cmd,   w_rx_cmd_nxt;
  logic       r_rx_dv,    w_rx_dv_nxt;
  logic [3:0] r_rxd,      w_rxd_nxt;
  logic       r_rx_er,    w_rx_er_nxt;
  logic       r_crs,      w_crs_nxt;

  logic       w_is_data;
  logic [3:0] w_nibble;
  logic       w_is_cmd;
  logic [1:0] w_cmd_code;
  logic [2:0] w_sil_inc;
  logic       w_strobe;
  logic [4:0] w_sym;

  assign w_strobe  = rx_if.rx_sym_valid;
  assign w_sym     = rx_if.rx_sym;
  assign w_sil_inc = r_sil_cnt + 3'd1;

  // Classify the incoming symbol as 4B/5B data or command
  always_comb begin
    w_is_data  = 1'b1;
    w_nibble   = 4'h0;
    w_is_cmd   = 1'b0;
    w_cmd_code = c_cmd_none;
    case (w_sym)
      5'b11110: w_nibble = 4'h0;
      5'b01001: w_nibble = 4'h1;
      5'b10100: w_nibble = 4'h2;
      5'b10101: w_nibble = 4'h3;
      5'b01010: w_nibble = 4'h4;
      5'b01011: w_nibble = 4'h5;
      5'b01110: w_nibble = 4'h6;
      5'b01111: w_nibble = 4'h7;
      5'b10010: w_nibble = 4'h8;
      5'b10011: w_nibble = 4'h9;
      5'b10110: w_nibble = 4'hA;
      5'b10111: w_nibble = 4'hB;
      5'b11010: w_nibble = 4'hC;
      5'b11011: w_nibble = 4'hD;
      5'b11100: w_nibble = 4'hE;
      5'b11101: w_nibble = 4'hF;
      default:  w_is_data = 1'b0;
    endcase
    case (w_sym)
      c_sym_beacon: begin w_is_cmd = 1'b1; w_cmd_code = c_cmd_beacon; end
      c_sym_commit: begin w_is_cmd = 1'b1; w_cmd_code = c_cmd_commit; end
      c_sym_hbeat:  begin w_is_cmd = 1'b1; w_cmd_code = c_cmd_hbeat;  end
      default:      ;
    endcase
  end

  // State register; reset always restarts the receiver in IDLE
  always_ff @(posedge clk or posedge pcs_reset) begin
    if (pcs_reset) r_state <= c_st_idle;
    else           r_state <= w_state_nxt;
  end

  // Next-state decode, advancing only on symbol strobes
  always_comb begin
    w_state_nxt = r_state;
    if (w_strobe) begin
      case (r_state)
        c_st_idle:     if (w_sym == c_sym_sync) w_state_nxt = c_st_sync1;
        c_st_sync1:    w_state_nxt = (w_sym == c_sym_sync) ? c_st_sync2 : c_st_idle;
        c_st_sync2: begin
          if (w_sym == c_sym_ssd)       w_state_nxt = c_st_data;
          else if (w_sym != c_sym_sync) w_state_nxt = c_st_idle;
        end
        c_st_data: begin
          if (w_sym == c_sym_esd) w_state_nxt = c_st_esd_seen;
          else if (w_sym == c_sym_silence && w_sil_inc == c_sil_abort)
            w_state_nxt = c_st_idle;
        end
        c_st_esd_seen: w_state_nxt = c_st_idle;
        default:       w_state_nxt = c_st_idle;
      endcase
    end
  end

  // Next values of outputs and counters; everything holds between strobes
  always_comb begin
    w_rx_cmd_nxt   = r_rx_cmd;
    w_rx_dv_nxt    = r_rx_dv;
    w_rxd_nxt      = r_rxd;
    w_rx_er_nxt    = r_rx_er;
    w_crs_nxt      = r_crs;
    w_cmd_cnt_nxt  = r_cmd_cnt;
    w_last_cmd_nxt = r_last_cmd;
    w_sil_cnt_nxt  = r_sil_cnt;
    if (w_strobe) begin
      case (r_state)
        c_st_idle: begin
          w_rx_dv_nxt = 1'b0;
          w_rx_er_nxt = 1'b0;
          if (w_is_cmd) begin
            // A zero count means no command run is in progress
            if (r_cmd_cnt != 3'd0 && w_cmd_code == r_last_cmd)
              w_cmd_cnt_nxt = (r_cmd_cnt == 3'd7) ? 3'd7 : r_cmd_cnt + 3'd1;
            else
              w_cmd_cnt_nxt = 3'd1;
            w_last_cmd_nxt = w_cmd_code;
            w_rx_cmd_nxt   = (w_cmd_cnt_nxt >= c_cmd_repeat) ? w_cmd_code : c_cmd_none;
          end else begin
            w_cmd_cnt_nxt = 3'd0;
            w_rx_cmd_nxt  = c_cmd_none;
            if (w_sym == c_sym_sync) w_crs_nxt = 1'b1;
          end
        end
        c_st_sync1: if (w_sym != c_sym_sync) w_crs_nxt = 1'b0;
        c_st_sync2: begin
          w_sil_cnt_nxt = 3'd0;
          if (w_sym != c_sym_sync && w_sym != c_sym_ssd) w_crs_nxt = 1'b0;
        end
        c_st_data: begin
          if (w_is_data) begin
            w_rx_dv_nxt   = 1'b1;
            w_rxd_nxt     = w_nibble;
            w_rx_er_nxt   = 1'b0;
            w_sil_cnt_nxt = 3'd0;
          end else if (w_sym == c_sym_esd) begin
            w_rx_dv_nxt   = 1'b0;
            w_rx_er_nxt   = 1'b0;
            w_sil_cnt_nxt = 3'd0;
          end else if (w_sym == c_sym_silence && w_sil_inc == c_sil_abort) begin
            w_rx_dv_nxt   = 1'b0;
            w_rx_er_nxt   = 1'b0;
            w_crs_nxt     = 1'b0;
            w_sil_cnt_nxt = 3'd0;
          end else begin
            // Errored nibble: RXD keeps the last good value
            w_rx_dv_nxt   = 1'b1;
            w_rx_er_nxt   = 1'b1;
            w_sil_cnt_nxt = (w_sym == c_sym_silence) ? w_sil_inc : 3'd0;
          end
        end
        c_st_esd_seen: begin
          w_rx_dv_nxt = 1'b0;
          w_crs_nxt   = 1'b0;
          w_rx_er_nxt = (w_sym != c_sym_esdok);
        end
        default: ;
      endcase
    end
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge pcs_reset) begin
    if (pcs_reset) begin
      r_rx_cmd   <= c_cmd_none;
      r_rx_dv    <= 1'b0;
      r_rxd      <= 4'h0;
      r_rx_er    <= 1'b0;
      r_crs      <= 1'b0;
      r_cmd_cnt  <= 3'd0;
      r_last_cmd <= c_cmd_none;
      r_sil_cnt  <= 3'd0;
    end else begin
      r_rx_cmd   <= w_rx_cmd_nxt;
      r_rx_dv    <= w_rx_dv_nxt;
      r_rxd      <= w_rxd_nxt;
      r_rx_er    <= w_rx_er_nxt;
      r_crs      <= w_crs_nxt;
      r_cmd_cnt  <= w_cmd_cnt_nxt;
      r_last_cmd <= w_last_cmd_nxt;
      r_sil_cnt  <= w_sil_cnt_nxt;
    end
  end

  assign rx_if.rx_cmd = r_rx_cmd;
  assign rx_if.RX_DV  = r_rx_dv;
  assign rx_if.RXD    = r_rxd;
  assign rx_if.RX_ER  = r_rx_er;
  assign rx_if.CRS    = r_crs;

`ifdef RX_SYM_ERR_CNT_EN
  logic       w_is_ctrl;
  logic       w_is_invalid;
  logic [7:0] r_sym_err_cnt;

  assign w_is_ctrl    = (w_sym == c_sym_silence) || (w_sym == c_sym_sync) ||
                        (w_sym == c_sym_ssd) || (w_sym == c_sym_esd) ||
                        (w_sym == c_sym_esdok);
  assign w_is_invalid = !(w_is_data || w_is_cmd || w_is_ctrl);

  // Saturating count of invalid codes seen in any state
  always_ff @(posedge clk or posedge pcs_reset) begin
    if (pcs_reset)
      r_sym_err_cnt <= 8'd0;
    else if (w_strobe && w_is_invalid && r_sym_err_cnt != 8'hFF)
      r_sym_err_cnt <= r_sym_err_cnt + 8'd1;
  end

  assign rx_if.sym_err_cnt = r_sym_err_cnt;
`else
  assign rx_if.sym_err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire
